// File: rtl/regfile_be.sv
// Two-read, one-write register file with per-byte write enables, optional
// hardwired zero register, optional write-through bypass and a saturating write counter.
module regfile_be #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic [AW-1:0]      waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [AW-1:0]      raddr_a,
    input  logic [AW-1:0]      raddr_b,
    output logic [WIDTH-1:0]   rdata_a,
    output logic [WIDTH-1:0]   rdata_b,
    output logic [15:0]        wr_count
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [15:0]      wr_count_q;
    logic [15:0]      wr_count_d;

    logic [WIDTH-1:0] bmask;
    logic [WIDTH-1:0] merged;
    logic             wr_zero;
    logic             wr_ok;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < NB; b++) begin
            bmask[8*b +: 8] = {8{wbe[b]}};
        end
    end

    // A write counts only when it actually lands in a register.
    always_comb begin
        wr_zero = (ZERO_REG != 0) && (waddr == '0);
        wr_ok   = !clr && en && (|wbe) && !wr_zero;
        merged  = (regs_q[waddr] & ~bmask) | (wdata & bmask);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_ok) begin
            regs_d[waddr] = merged;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_ok && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_count_q <= wr_count_d;
        end
    end

    // Zero forcing and clear take priority over the bypass path.
    always_comb begin
        rdata_a = regs_q[raddr_a];
        if ((BYPASS != 0) && wr_ok && (raddr_a == waddr)) begin
            rdata_a = merged;
        end
        if (clr || ((ZERO_REG != 0) && (raddr_a == '0))) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = regs_q[raddr_b];
        if ((BYPASS != 0) && wr_ok && (raddr_b == waddr)) begin
            rdata_b = merged;
        end
        if (clr || ((ZERO_REG != 0) && (raddr_b == '0))) begin
            rdata_b = '0;
        end
    end

    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile_be.sv
// Directed bench for regfile_be: a vector table for single-cycle behaviour plus
// hand sequences for ZERO_REG=0, asynchronous clear and counter saturation.
module tb_regfile_be;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;

    logic [31:0] rdata_a, rdata_b, nb_rdata_a, nb_rdata_b, nz_rdata_a, nz_rdata_b;
    logic [15:0] wr_count, nb_wr_count, nz_wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_be u_dut (
        .clk(clk), .clr(clr), .en(en), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .wr_count(wr_count)
    );

    regfile_be #(.BYPASS(0)) u_nobyp (
        .clk(clk), .clr(clr), .en(en), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(nb_rdata_a), .rdata_b(nb_rdata_b), .wr_count(nb_wr_count)
    );

    regfile_be #(.ZERO_REG(0)) u_nz (
        .clk(clk), .clr(clr), .en(en), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(nz_rdata_a), .rdata_b(nz_rdata_b), .wr_count(nz_wr_count)
    );

    typedef struct {
        logic        en;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_nb_b;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        en = e; waddr = wa; wdata = wd; wbe = be; raddr_a = ra; raddr_b = rb;
        #2;
    endtask

    initial begin
        //          en    waddr   wdata          wbe    ra     rb     exp_a          exp_b          exp_nb_b       cnt
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF, 5'd5,  5'd1,  32'hDEADBEEF, 32'h0,        32'h0,        16'd0};
        vecs[1]  = '{1'b0, 5'd5,  32'h0,        4'hF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
        vecs[2]  = '{1'b1, 5'd5,  32'h11223344, 4'h5, 5'd5,  5'd3,  32'hDE22BE44, 32'h0,        32'h0,        16'd1};
        vecs[3]  = '{1'b0, 5'd5,  32'h0,        4'h0, 5'd5,  5'd5,  32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 16'd2};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 5'd0,  5'd5,  32'h0,        32'hDE22BE44, 32'hDE22BE44, 16'd2};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        16'd2};
        vecs[6]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 4'hF, 5'd3,  5'd7,  32'h0,        32'hA5A5A5A5, 32'h0,        16'd2};
        vecs[7]  = '{1'b1, 5'd3,  32'hCAFEF00D, 4'h0, 5'd3,  5'd7,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 16'd3};
        vecs[8]  = '{1'b0, 5'd3,  32'h12345678, 4'hF, 5'd3,  5'd3,  32'h0,        32'h0,        32'h0,        16'd3};
        vecs[9]  = '{1'b1, 5'd31, 32'h01020304, 4'h8, 5'd31, 5'd31, 32'h01000000, 32'h01000000, 32'h0,        16'd3};
        vecs[10] = '{1'b1, 5'd31, 32'hAABBCCDD, 4'h2, 5'd31, 5'd7,  32'h0100CC00, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'd4};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd31, 5'd5,  32'h0100CC00, 32'hDE22BE44, 32'hDE22BE44, 16'd5};

        clr = 1'b1; en = 1'b0; waddr = '0; wdata = '0; wbe = '0; raddr_a = 5'd5; raddr_b = 5'd31;
        repeat (2) @(negedge clk);
        #2;
        check("reset_rdata_a", rdata_a, 32'h0);
        check("reset_rdata_b", rdata_b, 32'h0);
        check("reset_wr_count", {16'h0, wr_count}, 32'h0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].en, vecs[i].waddr, vecs[i].wdata, vecs[i].wbe, vecs[i].ra, vecs[i].rb);
            check($sformatf("vec%0d_rdata_a", i), rdata_a, vecs[i].exp_a);
            check($sformatf("vec%0d_rdata_b", i), rdata_b, vecs[i].exp_b);
            check($sformatf("vec%0d_nobyp_rdata_b", i), nb_rdata_b, vecs[i].exp_nb_b);
            check($sformatf("vec%0d_wr_count", i), {16'h0, wr_count}, {16'h0, vecs[i].exp_cnt});
        end

        // Register 0 is ordinary when ZERO_REG=0; it already took vec4's write.
        drive(1'b1, 5'd0, 32'h0F0F0F0F, 4'h3, 5'd0, 5'd0);
        check("nz_bypass_r0", nz_rdata_a, 32'hFFFF0F0F);
        check("zr_bypass_r0", rdata_a, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
        check("nz_stored_r0", nz_rdata_b, 32'hFFFF0F0F);
        check("zr_stored_r0", rdata_b, 32'h0);
        check("nz_wr_count", {16'h0, nz_wr_count}, 32'd7);
        check("zr_wr_count", {16'h0, wr_count}, 32'd5);

        // Asynchronous clear between edges, with a write presented meanwhile.
        drive(1'b0, 5'd9, 32'h0, 4'h0, 5'd5, 5'd31);
        #1;
        clr = 1'b1;
        #1;
        check("clr_async_rdata_a", rdata_a, 32'h0);
        check("clr_async_rdata_b", rdata_b, 32'h0);
        check("clr_async_wr_count", {16'h0, wr_count}, 32'h0);
        check("clr_async_nz_count", {16'h0, nz_wr_count}, 32'h0);
        drive(1'b1, 5'd9, 32'h13579BDF, 4'hF, 5'd9, 5'd9);
        check("clr_bypass_blocked", rdata_b, 32'h0);
        @(negedge clk);
        clr = 1'b0; en = 1'b0;
        #2;
        check("clr_write_ignored", rdata_a, 32'h0);
        check("clr_count_ignored", {16'h0, wr_count}, 32'h0);
        drive(1'b1, 5'd9, 32'h2468ACE0, 4'hF, 5'd9, 5'd9);
        drive(1'b0, 5'd9, 32'h0, 4'h0, 5'd9, 5'd9);
        check("post_clr_write", rdata_a, 32'h2468ACE0);
        check("post_clr_count", {16'h0, wr_count}, 32'd1);

        // Counter saturation.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; en = 1'b1; waddr = 5'd1; wdata = 32'h1; wbe = 4'h1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        #2;
        check("sat_fffe", {16'h0, wr_count}, 32'h0000FFFE);
        en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        #2;
        check("sat_ffff", {16'h0, wr_count}, 32'h0000FFFF);
        en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        #2;
        check("sat_hold", {16'h0, wr_count}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_be.md
REGFILE_BE -- requirements
Module: regfile_be

Interface
- REQ-001: Parameter WIDTH, default 32: data width in bits; SHALL be a multiple of 8, at least 8.
- REQ-002: Parameter DEPTH, default 32: number of registers; SHALL be a power of two, at least 2.
- REQ-003: Parameter AW, default 5: address width; SHALL equal log2(DEPTH).
- REQ-004: Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
- REQ-005: Parameter BYPASS, default 1: when 1, read ports return same-cycle write data (write-through).
- REQ-006: clk  input  1  clock; all register updates on posedge.
- REQ-007: clr  input  1  reset, asynchronous, active-high; clears every register.
- REQ-008: en  input  1  write enable.
- REQ-009: waddr  input  AW  write address.
- REQ-010: wdata  input  WIDTH  write data.
- REQ-011: wbe  input  WIDTH/8  byte write enables; bit i covers wdata[8i+7:8i].
- REQ-012: raddr_a  input  AW  read port A address.
- REQ-013: raddr_b  input  AW  read port B address.
- REQ-014: rdata_a  output  WIDTH  read port A data, combinational.
- REQ-015: rdata_b  output  WIDTH  read port B data, combinational.
- REQ-016: wr_count  output  16  count of committed writes since reset, saturating at 16'hFFFF.

Function
- REQ-017: Write: at posedge clk with clr low, en=1 and wbe[i]=1, byte i of register[waddr] SHALL take byte i of wdata.
- REQ-018: Bytes with wbe[i]=0 SHALL hold their value.
- REQ-019: en=0, or wbe all zero, SHALL leave all registers unchanged.
- REQ-020: With ZERO_REG=1, a write to address 0 SHALL be discarded, and reads of address 0 SHALL return 0 in every cycle, including under bypass.
- REQ-021: With ZERO_REG=0, register 0 SHALL behave as an ordinary register.
- REQ-022: Read with no address match: rdata_x SHALL equal register[raddr_x] as stored, with zero clock latency.
- REQ-023: Bypass, BYPASS=1, en=1, raddr_x == waddr, address not zero-forced: rdata_x SHALL return, per byte, wdata where wbe[i]=1 and the stored byte elsewhere.
- REQ-024: With BYPASS=0, the read in REQ-023 SHALL return the old stored value; the new value is visible from the next cycle.
- REQ-025: Both read ports SHALL be independent; the same address on both ports SHALL return identical data.
- REQ-026: wr_count SHALL increment by 1 on each posedge where clr=0, en=1, wbe is nonzero, and the write is not discarded under REQ-020.
- REQ-027: At 16'hFFFF, wr_count SHALL hold and never wrap to 0.
- REQ-028: Read ports SHALL not be gated by en; reads are always valid.

Reset
- REQ-029: While clr is high, all registers and wr_count SHALL be 0 immediately, without waiting for a clk edge, and SHALL stay 0.
- REQ-030: While clr is high, rdata_a and rdata_b SHALL read 0, bypass included.
- REQ-031: Writes presented while clr is high SHALL be ignored.
- REQ-032: Power-up (initial) value of all registers and wr_count SHALL be 0.
- REQ-033: clr asserted mid-burst SHALL abort the burst; the first write after clr deasserts SHALL take effect at the next posedge.

Verification
- REQ-034: Full-word write: en=1, waddr=5, wdata=32'hDEADBEEF, wbe=4'hF, then read raddr_a=5 next cycle -> rdata_a=32'hDEADBEEF; wr_count=1.
- REQ-035: Byte mask: reg5=32'hDEADBEEF, write wdata=32'h11223344 with wbe=4'b0101 -> reg5=32'hDE22BE44.
- REQ-036: Zero register: write waddr=0, wdata=32'hFFFFFFFF, wbe=4'hF -> rdata_a at raddr_a=0 reads 0 in the write cycle and afterward; wr_count unchanged.
- REQ-037: Bypass: reg7=0, same-cycle write waddr=7, wdata=32'hA5A5A5A5, wbe=4'hF with raddr_b=7 -> rdata_b=32'hA5A5A5A5 in that cycle with BYPASS=1, and 0 with BYPASS=0.
- REQ-038: Async clear: registers loaded; assert clr between clock edges -> all rdata and wr_count are 0 before the next posedge; a write with clr high is not stored.
- REQ-039: Saturation: preload wr_count to 16'hFFFE via 65534 writes, then 3 more writes -> wr_count=16'hFFFF and stays there.
